// File: rtl/dmar_rdata_pack.sv
`default_nettype none
// ============================================================================
// Module   : dmar_rdata_pack
// Purpose  : Packs byte-enabled DMA read beats into address-aligned 32b words
//            and queues them in a first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module dmar_rdata_pack #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr_i,
    input  logic        dma_dvld_i,
    input  logic [31:0] dma_rdata_i,
    input  logic [3:0]  dma_rbe_i,
    input  logic        dma_rd_last_i,
    output logic        dma_dack_o,
    output logic [5:0]  buf_empty_word_o,
    output logic        pk_vld_o,
    output logic [31:0] pk_data_o,
    output logic [3:0]  pk_be_o,
    output logic        pk_last_o,
    input  logic        pk_rdy_i
);

    localparam int              c_pw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0]      c_depth    = 6'(DEPTH);
    localparam logic [c_pw-1:0] c_last_idx = c_pw'(DEPTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [5:0]      count_q,    count_d;
    logic [c_pw-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_pw-1:0] rd_ptr_q,   rd_ptr_d;
    logic [23:0]     res_data_q, res_data_d;
    logic [1:0]      res_cnt_q,  res_cnt_d;

    logic [36:0]     mem [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic            w_accept;
    logic            w_pop;
    logic [2:0]      w_nbytes;
    logic [1:0]      w_off;
    logic [31:0]     w_inc_shift;
    logic [31:0]     w_inc_mask;
    logic [31:0]     w_inc;
    logic [55:0]     w_merged;
    logic [2:0]      w_total;
    logic            w_push0;
    logic            w_push1;
    logic [36:0]     w_ent0;
    logic [36:0]     w_ent1;
    logic [1:0]      w_npush;
    logic [c_pw-1:0] w_wr_ptr_p1;
    logic [36:0]     w_head;

    function automatic logic [c_pw-1:0] f_ptr_inc(input logic [c_pw-1:0] p);
        f_ptr_inc = (p == c_last_idx) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [3:0] f_be_low(input logic [2:0] k);
        case (k)
            3'd0:    f_be_low = 4'b0000;
            3'd1:    f_be_low = 4'b0001;
            3'd2:    f_be_low = 4'b0011;
            3'd3:    f_be_low = 4'b0111;
            default: f_be_low = 4'b1111;
        endcase
    endfunction

    // Two free entries are required so a last beat can always push two words.
    assign buf_empty_word_o = c_depth - count_q;
    assign dma_dack_o       = (buf_empty_word_o >= 6'd2) && !clr_i;
    assign w_accept         = dma_dvld_i && dma_dack_o;
    assign pk_vld_o         = (count_q != 6'd0);
    assign w_pop            = pk_vld_o && pk_rdy_i;

    // ------------------------------------------------------------------------
    // Lane decode: byte count and lowest enabled lane
    // ------------------------------------------------------------------------
    always_comb begin
        w_nbytes = 3'd0;
        w_off    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dma_rbe_i[i]) begin
                w_off = 2'(i);
            end
            w_nbytes = w_nbytes + {2'b00, dma_rbe_i[i]};
        end
    end

    always_comb begin
        case (w_nbytes)
            3'd0:    w_inc_mask = 32'h0000_0000;
            3'd1:    w_inc_mask = 32'h0000_00FF;
            3'd2:    w_inc_mask = 32'h0000_FFFF;
            3'd3:    w_inc_mask = 32'h00FF_FFFF;
            default: w_inc_mask = 32'hFFFF_FFFF;
        endcase
    end

    // Incoming bytes are masked so disabled lanes never leak into packed words.
    assign w_inc_shift = dma_rdata_i >> {w_off, 3'b000};
    assign w_inc       = w_inc_shift & w_inc_mask;
    assign w_merged    = ({24'h0, w_inc} << {res_cnt_q, 3'b000}) | {32'h0, res_data_q};
    assign w_total     = {1'b0, res_cnt_q} + w_nbytes;

    // ------------------------------------------------------------------------
    // Push decision and residue update
    // ------------------------------------------------------------------------
    always_comb begin
        w_push0    = 1'b0;
        w_push1    = 1'b0;
        w_ent0     = {1'b0, 4'b1111, w_merged[31:0]};
        w_ent1     = {1'b1, f_be_low(w_total - 3'd4), 8'h00, w_merged[55:32]};
        res_cnt_d  = res_cnt_q;
        res_data_d = res_data_q;
        if (w_accept) begin
            if (dma_rd_last_i) begin
                w_push0    = 1'b1;
                res_cnt_d  = 2'd0;
                res_data_d = 24'h0;
                if (w_total > 3'd4) begin
                    w_push1 = 1'b1;
                end else begin
                    w_ent0 = {1'b1, f_be_low(w_total), w_merged[31:0]};
                end
            end else if (w_total[2]) begin
                w_push0    = 1'b1;
                res_cnt_d  = w_total[1:0];
                res_data_d = w_merged[55:32];
            end else begin
                res_cnt_d  = w_total[1:0];
                res_data_d = w_merged[23:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------------
    assign w_npush     = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_wr_ptr_p1 = f_ptr_inc(wr_ptr_q);

    always_comb begin
        count_d  = count_q + {4'b0000, w_npush} - {5'b00000, w_pop};
        rd_ptr_d = w_pop ? f_ptr_inc(rd_ptr_q) : rd_ptr_q;
        case (w_npush)
            2'd1:    wr_ptr_d = w_wr_ptr_p1;
            2'd2:    wr_ptr_d = f_ptr_inc(w_wr_ptr_p1);
            default: wr_ptr_d = wr_ptr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= 6'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            res_cnt_q  <= 2'd0;
            res_data_q <= 24'h0;
        end else if (clr_i) begin
            count_q    <= 6'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            res_cnt_q  <= 2'd0;
            res_data_q <= 24'h0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            res_cnt_q  <= res_cnt_d;
            res_data_q <= res_data_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            mem[wr_ptr_q] <= w_ent0;
        end
        if (w_push1) begin
            mem[w_wr_ptr_p1] <= w_ent1;
        end
    end

    // ------------------------------------------------------------------------
    // Head presentation
    // ------------------------------------------------------------------------
    assign w_head    = mem[rd_ptr_q];
    assign pk_data_o = pk_vld_o ? w_head[31:0]  : 32'h0;
    assign pk_be_o   = pk_vld_o ? w_head[35:32] : 4'h0;
    assign pk_last_o = pk_vld_o ? w_head[36]    : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dmar_rdata_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmar_rdata_pack
// Purpose  : Scoreboard bench for dmar_rdata_pack packing, FIFO and flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmar_rdata_pack;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        dma_dvld;
    logic [31:0] dma_rdata;
    logic [3:0]  dma_rbe;
    logic        dma_rd_last;
    logic        dma_dack;
    logic [5:0]  buf_empty_word;
    logic        pk_vld;
    logic [31:0] pk_data;
    logic [3:0]  pk_be;
    logic        pk_last;
    logic        pk_rdy;

    logic [36:0] sb_q [$];
    logic [36:0] exp_word;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmar_rdata_pack #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .clr_i            (clr),
        .dma_dvld_i       (dma_dvld),
        .dma_rdata_i      (dma_rdata),
        .dma_rbe_i        (dma_rbe),
        .dma_rd_last_i    (dma_rd_last),
        .dma_dack_o       (dma_dack),
        .buf_empty_word_o (buf_empty_word),
        .pk_vld_o         (pk_vld),
        .pk_data_o        (pk_data),
        .pk_be_o          (pk_be),
        .pk_last_o        (pk_last),
        .pk_rdy_i         (pk_rdy)
    );

    task automatic check_val(input string tag, input logic [36:0] got, input logic [36:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] ent(input logic last, input logic [3:0] be, input logic [31:0] d);
        ent = {last, be, d};
    endfunction

    // Consumer side: every pop is compared against the oldest expected word.
    always @(negedge clk) begin
        if (rstn && !clr && pk_vld && pk_rdy) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_word", {pk_last, pk_be, pk_data}, 37'h0);
            end else begin
                exp_word = sb_q.pop_front();
                check_val("pk_word", {pk_last, pk_be, pk_data}, exp_word);
            end
        end
    end

    task automatic send_beat(input logic [3:0] be, input logic [31:0] d, input logic last);
        bit got = 0;
        dma_dvld    = 1'b1;
        dma_rbe     = be;
        dma_rdata   = d;
        dma_rd_last = last;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dma_dack) begin
                got = 1;
                break;
            end
        end
        if (!got) check_val("dack_timeout", {36'h0, dma_dack}, 37'h1);
        @(posedge clk);
        #1;
        dma_dvld    = 1'b0;
        dma_rd_last = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !pk_vld) begin
                done = 1;
                break;
            end
        end
        if (!done) check_val("drain_timeout", 37'(sb_q.size()), 37'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; clr = 1'b0; dma_dvld = 1'b0; dma_rdata = 32'h0;
        dma_rbe = 4'h0; dma_rd_last = 1'b0; pk_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_vld",   {36'h0, pk_vld},   37'h0);
        check_val("rst_data",  {5'h0, pk_data},   37'h0);
        check_val("rst_be",    {33'h0, pk_be},    37'h0);
        check_val("rst_last",  {36'h0, pk_last},  37'h0);
        check_val("rst_dack",  {36'h0, dma_dack}, 37'h1);
        check_val("rst_empty", {31'h0, buf_empty_word}, 37'd32);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Aligned stream
        pk_rdy = 1'b1;
        sb_q.push_back(ent(1'b0, 4'hF, 32'h0302_0100));
        sb_q.push_back(ent(1'b0, 4'hF, 32'h0706_0504));
        sb_q.push_back(ent(1'b1, 4'hF, 32'h0B0A_0908));
        send_beat(4'b1111, 32'h0302_0100, 1'b0);
        send_beat(4'b1111, 32'h0706_0504, 1'b0);
        send_beat(4'b1111, 32'h0B0A_0908, 1'b1);
        wait_drain();

        // Unaligned start, residue carried, total 4 on last
        sb_q.push_back(ent(1'b0, 4'hF, 32'h0403_0201));
        sb_q.push_back(ent(1'b1, 4'hF, 32'h0807_0605));
        send_beat(4'b1110, 32'h0302_01EE, 1'b0);
        send_beat(4'b1111, 32'h0706_0504, 1'b0);
        send_beat(4'b0001, 32'hDDCC_BB08, 1'b1);
        wait_drain();

        // Double push on last beat, observed with consumer stalled
        pk_rdy = 1'b0;
        sb_q.push_back(ent(1'b0, 4'hF, 32'h0605_0403));
        sb_q.push_back(ent(1'b1, 4'h1, 32'h0000_0007));
        send_beat(4'b1000, 32'h03AA_BBCC, 1'b0);
        check_val("dpush_empty0", {31'h0, buf_empty_word}, 37'd32);
        send_beat(4'b1111, 32'h0706_0504, 1'b1);
        check_val("dpush_empty1", {31'h0, buf_empty_word}, 37'd30);
        pk_rdy = 1'b1;
        wait_drain();

        // Short single beat, then an empty last beat
        sb_q.push_back(ent(1'b1, 4'b0011, 32'h0000_BBAA));
        send_beat(4'b0110, 32'h00BB_AA00, 1'b1);
        sb_q.push_back(ent(1'b1, 4'b0000, 32'h0000_0000));
        send_beat(4'b0000, 32'h1234_5678, 1'b1);
        sb_q.push_back(ent(1'b1, 4'b0111, 32'h0033_2211));
        send_beat(4'b0011, 32'hFFFF_2211, 1'b0);
        send_beat(4'b0001, 32'hEEEE_EE33, 1'b1);
        wait_drain();

        // Backpressure: fill to one free slot, then release the consumer
        pk_rdy = 1'b0;
        for (int i = 0; i < 31; i++) begin
            sb_q.push_back(ent(1'b0, 4'hF, 32'hC000_0000 | 32'(i)));
            send_beat(4'b1111, 32'hC000_0000 | 32'(i), 1'b0);
        end
        check_val("bp_empty", {31'h0, buf_empty_word}, 37'd1);
        check_val("bp_dack",  {36'h0, dma_dack},       37'h0);
        check_val("bp_head",  {pk_last, pk_be, pk_data}, ent(1'b0, 4'hF, 32'hC000_0000));
        sb_q.push_back(ent(1'b1, 4'hF, 32'hC000_001F));
        pk_rdy = 1'b1;
        send_beat(4'b1111, 32'hC000_001F, 1'b1);
        wait_drain();

        // Flush with queued words and a partial residue
        pk_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_beat(4'b1111, 32'h5500_0000 | 32'(i), 1'b0);
        end
        send_beat(4'b0011, 32'h0000_9988, 1'b0);
        check_val("clr_pre_empty", {31'h0, buf_empty_word}, 37'd27);
        clr = 1'b1;
        #1;
        check_val("clr_dack", {36'h0, dma_dack}, 37'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_val("clr_vld",   {36'h0, pk_vld},         37'h0);
        check_val("clr_empty", {31'h0, buf_empty_word}, 37'd32);
        pk_rdy = 1'b1;
        sb_q.push_back(ent(1'b1, 4'hF, 32'hA3A2_A1A0));
        send_beat(4'b1111, 32'hA3A2_A1A0, 1'b1);
        wait_drain();

        // Reset mid-transfer discards everything
        pk_rdy = 1'b0;
        send_beat(4'b1111, 32'h1111_1111, 1'b0);
        send_beat(4'b0011, 32'h0000_2222, 1'b0);
        rstn = 1'b0;
        #2;
        check_val("mrst_vld",   {36'h0, pk_vld},         37'h0);
        check_val("mrst_empty", {31'h0, buf_empty_word}, 37'd32);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        pk_rdy = 1'b1;
        sb_q.push_back(ent(1'b1, 4'hF, 32'h0D0C_0B0A));
        send_beat(4'b1111, 32'h0D0C_0B0A, 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmar_rdata_pack.md
DMAR_RDATA_PACK -- requirements
Module: dmar_rdata_pack

Interface
REQ-001 Parameter DEPTH, default 32, FIFO depth in 32b words; legal 4..32 (buf_empty_word is 6 bits).
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous flush, pulsed at 1D DMA start.
REQ-005 dma_dvld  input  1  upstream read beat valid.
REQ-006 dma_rdata  input  32  upstream beat data; byte lane 0 = lowest address.
REQ-007 dma_rbe  input  4  upstream byte enables; set lanes contiguous.
REQ-008 dma_rd_last  input  1  last beat of the 1D DMA.
REQ-009 dma_dack  output  1  beat accepted when dma_dvld & dma_dack.
REQ-010 buf_empty_word  output  6  free FIFO entries, DEPTH - count.
REQ-011 pk_vld  output  1  packed word available.
REQ-012 pk_data  output  32  packed, address-aligned data; byte 0 first.
REQ-013 pk_be  output  4  valid bytes of pk_data; 4'b1111 except last word.
REQ-014 pk_last  output  1  final word of the 1D DMA.
REQ-015 pk_rdy  input  1  consumer pop, pop = pk_vld & pk_rdy.

Function
REQ-016 Residue register: res_data 24b, res_cnt 2b (0..3 bytes), holds bytes not yet forming a full word.
REQ-017 On accept: n = popcount(dma_rbe) (0..4), off = index of lowest set lane; incoming bytes = dma_rdata >> 8*off; total = res_cnt + n (0..7).
REQ-018 Push word = res_data low res_cnt bytes then incoming bytes, little-endian order; pk_be 4'b1111 for full words.
REQ-019 Not last: total>=4 -> push 1 full word, res_cnt = total-4, res_data = leftover bytes; total<4 -> no push, res_cnt = total.
REQ-020 Last: total<4, total>0 -> push 1 word, pk_be = (1<<total)-1, pk_last=1; total==4 -> 1 full word, pk_last=1; total 5..7 -> full word then word with pk_be=(1<<(total-4))-1, pk_last=1 on second only; total==0 -> push word pk_be=4'b0000, pk_last=1.
REQ-021 After any last beat res_cnt = 0, res_data = 0.
REQ-022 dma_dack = (buf_empty_word >= 2) & !clr; combinational, no dependency on dma_dvld.
REQ-023 FIFO entry = {pk_last, pk_be, pk_data}, 37b, DEPTH entries, write pointer wraps modulo DEPTH; up to 2 writes per cycle.
REQ-024 First-word-fall-through: word pushed in cycle N is visible on pk_vld/pk_data from cycle N+1.
REQ-025 count += pushes (0..2) - pop (0..1); simultaneous push and pop in one cycle both take effect.
REQ-026 pk_vld = (count != 0); pk_data/pk_be/pk_last reflect head entry; stable while pk_vld & !pk_rdy.
REQ-027 Full: count==DEPTH -> buf_empty_word=0, dma_dack=0; never overwrites.
REQ-028 Empty: pk_vld=0, pk_rdy ignored, count never underflows.
REQ-029 clr priority over push/pop: same cycle count=0, pointers=0, res_cnt=0; accepted beat that cycle impossible (dack=0).
REQ-030 dma_rbe with non-contiguous lanes is illegal; behaviour per REQ-017 arithmetic only, no checking.

Reset
REQ-031 rstn low: count=0, pointers=0, res_cnt=0, res_data=0.
REQ-032 Outputs during/after reset: pk_vld=0, pk_data=0, pk_be=0, pk_last=0, dma_dack=1, buf_empty_word=DEPTH.
REQ-033 Reset mid-transfer discards FIFO content and residue; no partial word emitted.

Verification
REQ-034 Aligned: 3 beats rbe=1111 data 0x03020100,0x07060504,0x0B0A0908 (last) -> same 3 words, be=1111, pk_last on 3rd only.
REQ-035 Unaligned: beats rbe=1110 data 0x030201XX, rbe=1111 0x07060504, rbe=0001 0xXXXXXX08 last -> words 0x04030201 be1111, 0x08070605 be1111 last.
REQ-036 Double push: rbe=1000 0x03XXXXXX, rbe=1111 0x07060504 last -> 0x06050403 be1111, 0x00000007 be0001 last, both pushed same cycle, buf_empty_word drops by 2.
REQ-037 Backpressure: pk_rdy=0, DEPTH=32, stream aligned beats -> dack falls when buf_empty_word=1 after 31 pushes; raise pk_rdy -> dack returns, no word lost or duplicated.
REQ-038 Short: single beat rbe=0110 data 0x00BBAA00 last -> one word 0x0000BBAA be0011 last.
REQ-039 clr with 5 words queued and res_cnt=2 -> next cycle pk_vld=0, buf_empty_word=32; next aligned beat emitted unshifted.
